// File: rtl/branch_seek_unit.sv
// Bracket matcher for the branch path: scans forward from a CBF or backward from a CBB,
// tracking nesting depth, and reports the matching bracket address + 1 to the core.
package definitions;
    typedef enum logic [3:0] {
        NOP, INC, DEC, PTR_INC, PTR_DEC, PUT, GET, CBF, CBB
    } op_code;
endpackage

module branch_seek_unit
    import definitions::*;
#(
    parameter int PC_W    = 16,
    parameter int DEPTH_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dir,
    input  logic [PC_W-1:0] start_pc,
    input  logic            abort,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_valid,
    input  op_code          fetch_op,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] target_pc,
    output logic            error,
    output logic [1:0]      err_code
);
    typedef enum logic [1:0] {IDLE, SEEK, DONE, FAIL} state_t;

    localparam logic [PC_W-1:0]    PC_MAX    = '1;
    localparam logic [PC_W-1:0]    PC_ONE    = PC_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [1:0]         ERR_DEPTH = 2'b01;
    localparam logic [1:0]         ERR_WRAP  = 2'b10;

    state_t             state_reg;
    logic [DEPTH_W-1:0] depth_reg;
    logic               dir_reg;

    logic            is_opener;
    logic            is_closer;
    logic            at_limit;
    logic            depth_full;
    logic            last_close;
    logic            start_wrap;
    logic [PC_W-1:0] step_addr;
    logic [PC_W-1:0] first_addr;

    // Opener/closer roles swap with the scan direction.
    always_comb begin
        is_opener  = dir_reg ? (fetch_op == CBB) : (fetch_op == CBF);
        is_closer  = dir_reg ? (fetch_op == CBF) : (fetch_op == CBB);
        at_limit   = dir_reg ? (fetch_addr == '0) : (fetch_addr == PC_MAX);
        step_addr  = dir_reg ? (fetch_addr - PC_ONE) : (fetch_addr + PC_ONE);
        depth_full = (depth_reg == DEPTH_MAX);
        last_close = (depth_reg == DEPTH_ONE);
        start_wrap = dir ? (start_pc == '0) : (start_pc == PC_MAX);
        first_addr = dir ? (start_pc - PC_ONE) : (start_pc + PC_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            depth_reg  <= '0;
            dir_reg    <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            target_pc  <= '0;
            err_code   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        depth_reg  <= DEPTH_ONE;
                        dir_reg    <= dir;
                        fetch_addr <= first_addr;
                        target_pc  <= '0;
                        if (start_wrap) begin
                            state_reg <= FAIL;
                            error     <= 1'b1;
                            err_code  <= ERR_WRAP;
                        end else begin
                            state_reg <= SEEK;
                            busy      <= 1'b1;
                            fetch_req <= 1'b1;
                            err_code  <= '0;
                        end
                    end
                end
                SEEK: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        fetch_req <= 1'b0;
                    end else if (fetch_valid) begin
                        // Termination checks take priority over the address step.
                        if (is_opener && depth_full) begin
                            state_reg <= FAIL;
                            busy      <= 1'b0;
                            fetch_req <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_DEPTH;
                        end else if (is_closer && last_close) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            fetch_req <= 1'b0;
                            done      <= 1'b1;
                            target_pc <= fetch_addr + PC_ONE;
                            depth_reg <= '0;
                        end else if (at_limit) begin
                            state_reg <= FAIL;
                            busy      <= 1'b0;
                            fetch_req <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_WRAP;
                        end else begin
                            fetch_addr <= step_addr;
                            if (is_opener) begin
                                depth_reg <= depth_reg + DEPTH_ONE;
                            end else if (is_closer) begin
                                depth_reg <= depth_reg - DEPTH_ONE;
                            end
                        end
                    end
                end
                DONE, FAIL: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    fetch_req <= 1'b0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_seek_unit.sv
// Bench for branch_seek_unit: two instances (deep and shallow depth counter) share stimulus
// and a program memory; a scan-level model predicts each seek's outcome and per-cycle outputs.
module tb_branch_seek_unit;
    import definitions::*;

    localparam int KIND_DONE = 1;
    localparam int KIND_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [15:0] start_pc;
    logic        abort;
    logic        fetch_valid;

    logic        fetch_req_a  [2];
    logic [15:0] fetch_addr_a [2];
    op_code      fetch_op_a   [2];
    logic        busy_a       [2];
    logic        done_a       [2];
    logic [15:0] target_pc_a  [2];
    logic        error_a      [2];
    logic [1:0]  err_code_a   [2];

    op_code mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign fetch_op_a[gi] = mem[fetch_addr_a[gi]];
            branch_seek_unit #(.PC_W(16), .DEPTH_W(gi == 0 ? 8 : 2)) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start),
                .dir        (dir),
                .start_pc   (start_pc),
                .abort      (abort),
                .fetch_req  (fetch_req_a[gi]),
                .fetch_addr (fetch_addr_a[gi]),
                .fetch_valid(fetch_valid),
                .fetch_op   (fetch_op_a[gi]),
                .busy       (busy_a[gi]),
                .done       (done_a[gi]),
                .target_pc  (target_pc_a[gi]),
                .error      (error_a[gi]),
                .err_code   (err_code_a[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome of a whole seek, computed by walking the program memory directly.
    function automatic void predict(input logic [15:0] pc, input logic d, input int dmax,
                                    output int n, output int kind,
                                    output logic [15:0] tgt, output logic [1:0] code);
        int          depth;
        logic [15:0] a;
        n = 0; kind = KIND_ERR; tgt = 16'h0; code = 2'b10;
        if ((!d && pc == 16'hFFFF) || (d && pc == 16'h0000)) return;
        depth = 1;
        a = d ? pc - 16'd1 : pc + 16'd1;
        for (int s = 0; s < 70000; s++) begin
            n++;
            if (mem[a] == (d ? CBB : CBF)) begin
                if (depth == dmax) begin
                    code = 2'b01;
                    return;
                end
                depth++;
            end else if (mem[a] == (d ? CBF : CBB)) begin
                depth--;
                if (depth == 0) begin
                    kind = KIND_DONE; tgt = a + 16'd1; code = 2'b00;
                    return;
                end
            end
            if ((!d && a == 16'hFFFF) || (d && a == 16'h0000)) return;
            a = d ? a - 16'd1 : a + 16'd1;
        end
    endfunction

    // Model state per instance: 0 idle, 1 scanning, 2 result cycle.
    int          ph     [2] = '{0, 0};
    int          k      [2] = '{0, 0};
    int          pn     [2] = '{0, 0};
    int          pk     [2] = '{0, 0};
    logic [15:0] ptgt   [2];
    logic [1:0]  perr   [2];
    logic [15:0] pexp   [2];
    logic        pdir   [2];
    logic [15:0] mt     [2] = '{16'h0, 16'h0};
    logic [1:0]  me     [2] = '{2'b0, 2'b0};
    int          bcnt   [2] = '{0, 0};
    int          rec_kind [2] = '{0, 0};
    int          rec_n    [2] = '{0, 0};
    int          rec_busy [2] = '{0, 0};
    logic [15:0] rec_tgt  [2];
    logic [1:0]  rec_code [2];
    int          done_seen [2] = '{0, 0};
    int          err_seen  [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            string p;
            p = $sformatf("dut%0d_", i);
            if (!rst_n) begin
                chk({p, "reset_outputs"},
                    {busy_a[i], done_a[i], error_a[i], fetch_req_a[i], fetch_addr_a[i],
                     target_pc_a[i], err_code_a[i]}, 64'h0);
                ph[i] = 0; mt[i] = 16'h0; me[i] = 2'b0;
            end else begin
                chk({p, "exclusive"}, 64'(int'(busy_a[i]) + int'(done_a[i]) + int'(error_a[i]) > 1), 64'h0);
                chk({p, "target_pc"}, target_pc_a[i], mt[i]);
                chk({p, "err_code"}, err_code_a[i], me[i]);
                if (done_a[i]) done_seen[i]++;
                if (error_a[i]) err_seen[i]++;
                case (ph[i])
                    0: begin
                        chk({p, "idle_out"}, {busy_a[i], done_a[i], error_a[i], fetch_req_a[i]}, 4'b0000);
                        if (start && !abort) begin
                            predict(start_pc, dir, (i == 0) ? 255 : 3, pn[i], pk[i], ptgt[i], perr[i]);
                            pdir[i] = dir;
                            pexp[i] = dir ? start_pc - 16'd1 : start_pc + 16'd1;
                            k[i] = 0; bcnt[i] = 0; mt[i] = 16'h0; me[i] = 2'b0;
                            if (pn[i] == 0) begin
                                ph[i] = 2; mt[i] = ptgt[i]; me[i] = perr[i];
                            end else begin
                                ph[i] = 1;
                            end
                        end
                    end
                    1: begin
                        chk({p, "seek_out"}, {busy_a[i], done_a[i], error_a[i], fetch_req_a[i]}, 4'b1001);
                        chk({p, "fetch_addr"}, fetch_addr_a[i], pexp[i]);
                        bcnt[i]++;
                        if (abort) begin
                            ph[i] = 0;
                        end else if (fetch_valid) begin
                            k[i]++;
                            if (k[i] == pn[i]) begin
                                ph[i] = 2; mt[i] = ptgt[i]; me[i] = perr[i];
                            end else begin
                                pexp[i] = pdir[i] ? pexp[i] - 16'd1 : pexp[i] + 16'd1;
                            end
                        end
                    end
                    default: begin
                        chk({p, "result_out"}, {busy_a[i], done_a[i], error_a[i], fetch_req_a[i]},
                            {1'b0, pk[i] == KIND_DONE, pk[i] == KIND_ERR, 1'b0});
                        rec_kind[i] = done_a[i] ? KIND_DONE : (error_a[i] ? KIND_ERR : 0);
                        rec_n[i] = k[i]; rec_busy[i] = bcnt[i];
                        rec_tgt[i] = target_pc_a[i]; rec_code[i] = err_code_a[i];
                        ph[i] = 0;
                    end
                endcase
            end
        end
    end

    // fetch_valid: tied high, held low, or one valid cycle out of four.
    logic vmode = 1'b0;
    logic vhigh = 1'b1;
    int   vcnt  = 0;
    initial begin
        fetch_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (vmode) begin
                vcnt++;
                fetch_valid = (vcnt % 4 == 0);
            end else begin
                fetch_valid = vhigh;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(ph[0] == 0 && ph[1] == 0) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n >= bound), 64'h0);
        tick();
    endtask

    task automatic seek(input logic d, input logic [15:0] pc);
        start = 1'b1; dir = d; start_pc = pc;
        tick();
        start = 1'b0;
        wait_idle(400);
    endtask

    int d0, e0;

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; start_pc = 16'h0; abort = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = NOP;
        mem[16'h11] = INC; mem[16'h12] = CBF; mem[16'h13] = DEC; mem[16'h14] = CBB; mem[16'h15] = CBB;
        mem[16'h1F] = CBB; mem[16'h1E] = INC; mem[16'h1D] = CBF; mem[16'h1C] = CBF;
        for (int a = 16'h40; a < 16'h43; a++) mem[a] = CBF;
        for (int a = 16'h43; a < 16'h47; a++) mem[a] = CBB;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: forward, valid tied high
        seek(1'b0, 16'h0010);
        chk("t1_target", rec_tgt[0], 16'h0016);
        chk("t1_fetches", rec_n[0], 5);
        chk("t1_busy_cycles", rec_busy[0], 5);
        chk("t1_kind", rec_kind[0], KIND_DONE);

        // 2: backward
        seek(1'b1, 16'h0020);
        chk("t2_target", rec_tgt[0], 16'h001D);
        chk("t2_busy_cycles", rec_busy[0], 4);

        // 3: slow fetch, plus a start pulse mid-seek that must be ignored
        vmode = 1'b1; vcnt = 0;
        start = 1'b1; dir = 1'b0; start_pc = 16'h0010;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; start_pc = 16'h0100;
        tick();
        start = 1'b0;
        wait_idle(400);
        vmode = 1'b0;
        chk("t3_target", rec_tgt[0], 16'h0016);
        chk("t3_fetches", rec_n[0], 5);

        // 4: nesting deeper than the shallow instance can count
        seek(1'b0, 16'h003F);
        chk("t4_deep_target", rec_tgt[0], 16'h0047);
        chk("t4_shallow_kind", rec_kind[1], KIND_ERR);
        chk("t4_shallow_code", rec_code[1], 2'b01);
        chk("t4_shallow_fetches", rec_n[1], 3);

        // 5: address wrap during scan and at start
        seek(1'b0, 16'hFFFD);
        chk("t5_code", rec_code[0], 2'b10);
        chk("t5_fetches", rec_n[0], 2);
        seek(1'b0, 16'hFFFF);
        chk("t5_startwrap_fwd_code", rec_code[0], 2'b10);
        chk("t5_startwrap_fwd_fetches", rec_n[0], 0);
        seek(1'b1, 16'h0000);
        chk("t5_startwrap_bwd_kind", rec_kind[0], KIND_ERR);

        // 6: abort mid-seek, abort beating start, reset mid-seek
        d0 = done_seen[0]; e0 = err_seen[0];
        start = 1'b1; dir = 1'b0; start_pc = 16'h0010;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(50);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        tick();
        chk("t6_abort_start_busy", busy_a[0], 1'b0);
        vhigh = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("t6_seeking_before_reset", busy_a[0], 1'b1);
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        vhigh = 1'b1;
        tick();
        chk("t6_addr_after_reset", fetch_addr_a[0], 16'h0);
        chk("t6_no_done", done_seen[0], d0);
        chk("t6_no_error", err_seen[0], e0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
